ex_stage_unit: RTL and testbench
================================

Name: ex_stage_unit

Overview:
Execute-stage datapath of the pipelined 64-bit ARM-subset CPU. It selects ALU operands through forwarding and immediate multiplexers and computes the ALU result. It holds the architectural condition flags (N, Z, V, C) in registers. It also computes the branch target PC + (offset << 2). It sits between the ID/EX and EX/MEM pipeline registers.

Parameters:
WIDTH, 64, datapath width. All data ports, the ALU and the branch adder use it. Only 64 is required to work.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high; clears the flag registers.
ReadData1  in  64  register-file operand A.
ReadData2  in  64  register-file operand B.
PC  in  64  PC of the instruction in EX.
ALU_or_DT  in  64  sign/zero-extended immediate or DT address offset.
BR_to_shift  in  64  sign-extended branch offset, in words.
alu_result_mem  in  64  ALU result in EX/MEM, used for forwarding.
alu_result_wb  in  64  result in MEM/WB, used for forwarding.
ALUop  in  3  ALU operation select.
forwardA  in  2  operand-A forwarding select.
forwardB  in  2  operand-B forwarding select.
ALUsrc  in  1  1 = immediate as B, 0 = ReadData2.
update  in  1  1 = write ALU flags into the flag registers at the next edge.
cbz_id  in  1  1 = instruction is CBZ; the zero output becomes the live ALU zero.
alu_result  out  64  ALU result, combinational.
new_PC2  out  64  branch target, combinational.
negative  out  1  registered N flag.
zero  out  1  Z flag (registered, or live when cbz_id=1).
overflow  out  1  registered V flag.
carry_out  out  1  registered C flag.

Behaviour:
Operand selection:
- bsrc = ALUsrc ? ALU_or_DT : ReadData2.
- Da: forwardA 00 → ReadData1, 01 → alu_result_wb, 10 → alu_result_mem, 11 → ReadData1.
- Db: forwardB 00 → bsrc, 01 → alu_result_wb, 10 → alu_result_mem, 11 → bsrc.
- Forwarding on B overrides the immediate select.

ALU (combinational, modulo 2^64):
- 000: result = Db.
- 010: result = Da + Db.
- 011: result = Da − Db, computed as Da + ~Db + 1.
- 100: result = Da & Db.
- 101: result = Da | Db.
- 110: result = Da ^ Db.
- 001 and 111: result = 0; all flags computed from that result with V=0, C=0.

ALU flags:
- n = result[63].
- z = (result == 0).
- For add/sub: c = carry out of bit 63; v = carry into bit 63 XOR carry out of bit 63.
- For pass-B and logic ops: c = 0, v = 0.

Flag registers (negative, zero, overflow, carry_out):
- reset=1 at an edge: all flags cleared to 0. Reset has priority over update.
- update=1 at an edge: registers take the ALU n, z, v, c.
- update=0: registers hold their values.
- cbz_id has no effect on register writes.

Flag outputs:
- negative, overflow, carry_out always show the registered values.
- zero = cbz_id ? live ALU z : registered Z. This is a combinational path.

Branch target:
- new_PC2 = PC + (BR_to_shift << 2), modulo 2^64.
- The upper two bits of BR_to_shift are discarded.

Latency:
- alu_result, new_PC2 and the live zero: 0 cycles.
- Registered flags: visible 1 cycle after the update edge.
- No handshake.

Optional Feature:
Macro EX_FORWARDING_EN.
- Defined: forwarding muxes behave as specified above.
- Undefined: forwardA and forwardB are ignored; Da = ReadData1 and Db = bsrc always.
- The ports remain present in both builds.

Test Plan:
1. Add, flags held: reset 1 cycle. RD1=0x2AA, RD2=0x155, ALUop=010, ALUsrc=0, update=0, BR_to_shift=2, PC=0 → alu_result=0x3FF, new_PC2=0x8, all flags 0 after the edge.
2. Immediate with update: ALUsrc=1, ALU_or_DT=1, update=1, BR_to_shift=0x80 → alu_result=0x2AB, new_PC2=0x200. After the edge: N=Z=V=C=0.
3. Negative result, flags held: RD1=0xFFFF_FFFF_FFFF_FAAA, imm=1, update=0 → alu_result=0xFFFF_FFFF_FFFF_FAAB. Flags stay 0. Repeat with update=1 → negative=1 after the edge.
4. Subtract equal: RD1=RD2=5, ALUop=011, ALUsrc=0, update=1 → result 0. After the edge: zero=1, carry_out=1, negative=0, overflow=0. Then 0x7FFF…FFFF + 1 with update → overflow=1, negative=1.
5. CBZ bypass: registered Z=0, cbz_id=1, ALUop=000, Db=0 → zero=1 in the same cycle with no edge needed. Drop cbz_id → zero returns to the registered 0.
6. Forwarding and reset:
   - forwardA=10, forwardB=01, mem=0x10, wb=0x3, ALUop=010 → alu_result=0x13.
   - forwardA=11 or forwardB=11 → register/immediate operand is used.
   - Assert reset together with update=1 → all flags 0.

Source files
------------

// File: rtl/ex_stage_unit.sv
// ---------------------------------------------------------------------------
// ex_stage_unit
//
// Execute stage of the pipelined 64-bit ARM-subset CPU. The block does four
// jobs:
//   - picks the ALU operands through the forwarding and immediate muxes,
//   - computes the ALU result,
//   - keeps the architectural N/Z/V/C flags in registers,
//   - computes the branch target PC + (offset << 2).
//
// Build option:
//   EX_FORWARDING_EN
//     Defined:   forwardA/forwardB steer the operands. They can pick the
//                EX/MEM or MEM/WB result.
//     Undefined: the forwarding selects are ignored. Da is always ReadData1
//                and Db is always the immediate/register choice. The ports
//                stay present in both builds.
//
// Ports:
//   clk, reset          rising-edge clock; synchronous active-high reset that
//                       clears the flag registers
//   ReadData1/2         register-file operands A and B
//   PC                  PC of the instruction currently in EX
//   ALU_or_DT           extended immediate or DT address offset
//   BR_to_shift         sign-extended branch offset, in words
//   alu_result_mem/wb   forwarded results from EX/MEM and MEM/WB
//   ALUop               000 pass B, 010 add, 011 sub, 100 and, 101 or,
//                       110 xor; 001 and 111 produce zero
//   forwardA/forwardB   01 = MEM/WB result, 10 = EX/MEM result,
//                       otherwise the normal operand
//   ALUsrc              1 = immediate is operand B
//   update              1 = load the ALU flags at the next edge
//   cbz_id              1 = drive zero from the live ALU result
//   alu_result, new_PC2 combinational ALU result and branch target
//   negative, zero, overflow, carry_out
//                       flag outputs (zero can be live, see above)
// ---------------------------------------------------------------------------
module ex_stage_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ReadData1,
  input  logic [WIDTH-1:0] ReadData2,
  input  logic [WIDTH-1:0] PC,
  input  logic [WIDTH-1:0] ALU_or_DT,
  input  logic [WIDTH-1:0] BR_to_shift,
  input  logic [WIDTH-1:0] alu_result_mem,
  input  logic [WIDTH-1:0] alu_result_wb,
  input  logic [2:0]       ALUop,
  input  logic [1:0]       forwardA,
  input  logic [1:0]       forwardB,
  input  logic             ALUsrc,
  input  logic             update,
  input  logic             cbz_id,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] new_PC2,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  localparam logic [2:0] OP_PASS_B = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_SUB    = 3'b011;
  localparam logic [2:0] OP_AND    = 3'b100;
  localparam logic [2:0] OP_OR     = 3'b101;
  localparam logic [2:0] OP_XOR    = 3'b110;

  logic [WIDTH-1:0] b_src;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   arith_sum;
  logic [WIDTH-1:0] arith_b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_n;
  logic             alu_z;
  logic             alu_v;
  logic             alu_c;
  logic             neg_q;
  logic             zero_q;
  logic             ovf_q;
  logic             carry_q;
  logic             unused_bits;

  assign b_src = ALUsrc ? ALU_or_DT : ReadData2;

  // Operand muxes. A forwarded value on B takes priority over the
  // immediate select. Code 11 falls back to the normal operand.
`ifdef EX_FORWARDING_EN
  always_comb begin
    op_a = ReadData1;
    op_b = b_src;
    case (forwardA)
      2'b01:   op_a = alu_result_wb;
      2'b10:   op_a = alu_result_mem;
      default: op_a = ReadData1;
    endcase
    case (forwardB)
      2'b01:   op_b = alu_result_wb;
      2'b10:   op_b = alu_result_mem;
      default: op_b = b_src;
    endcase
  end

  assign unused_bits = ^BR_to_shift[WIDTH-1:WIDTH-2];
`else
  assign op_a = ReadData1;
  assign op_b = b_src;

  assign unused_bits = ^{forwardA, forwardB, alu_result_mem, alu_result_wb,
                         BR_to_shift[WIDTH-1:WIDTH-2]};
`endif

  // ALU. Add and subtract share one WIDTH+1 bit adder, which exposes the
  // carry out of the top bit directly. Subtract is A + ~B + 1. The carry
  // into the top bit is recovered from the sum bit as a ^ b ^ s, and V is
  // that carry-in XOR the carry-out.
  always_comb begin
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    arith_b   = op_b;
    arith_sum = '0;
    case (ALUop)
      OP_PASS_B: alu_res = op_b;
      OP_ADD, OP_SUB: begin
        arith_b   = (ALUop == OP_SUB) ? ~op_b : op_b;
        arith_sum = {1'b0, op_a} + {1'b0, arith_b} +
                    {{WIDTH{1'b0}}, (ALUop == OP_SUB)};
        alu_res   = arith_sum[WIDTH-1:0];
        alu_c     = arith_sum[WIDTH];
        alu_v     = (op_a[WIDTH-1] ^ arith_b[WIDTH-1] ^ arith_sum[WIDTH-1])
                    ^ arith_sum[WIDTH];
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      default: alu_res = '0;
    endcase
  end

  assign alu_n      = alu_res[WIDTH-1];
  assign alu_z      = (alu_res == '0);
  assign alu_result = alu_res;

  // Flag registers. Reset wins over update. cbz_id only affects the zero
  // output mux and never the stored flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      carry_q <= 1'b0;
    end else if (update) begin
      neg_q   <= alu_n;
      zero_q  <= alu_z;
      ovf_q   <= alu_v;
      carry_q <= alu_c;
    end
  end

  assign negative  = neg_q;
  assign overflow  = ovf_q;
  assign carry_out = carry_q;
  // CBZ reads the live ALU zero in the same cycle.
  assign zero      = cbz_id ? alu_z : zero_q;

  // Branch target. The word offset is shifted left by two, so its top two
  // bits fall off.
  assign new_PC2 = PC + {BR_to_shift[WIDTH-3:0], 2'b00};

endmodule

// File: tb/tb_ex_stage_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_stage_unit
//
// Self-checking bench for ex_stage_unit.
//
// The reference model works from the arithmetic rules:
//   - unsigned compare gives the carry,
//   - sign comparison gives the overflow,
//   - plain 64-bit math gives the result and the branch target.
//
// The flag registers are mirrored by model variables. These are updated
// just before each rising edge. The forwarding model follows
// EX_FORWARDING_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_ex_stage_unit;

  typedef struct packed {
    logic [63:0] r;
    logic        n;
    logic        z;
    logic        v;
    logic        c;
  } alu_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] ReadData1, ReadData2, PC, ALU_or_DT, BR_to_shift;
  logic [63:0] alu_result_mem, alu_result_wb;
  logic [2:0]  ALUop;
  logic [1:0]  forwardA, forwardB;
  logic        ALUsrc, update, cbz_id;
  logic [63:0] alu_result, new_PC2;
  logic        negative, zero, overflow, carry_out;

  // Model of the architectural flags: N, Z, V, C.
  logic [3:0]  m_flags;
  int          tests_run;
  int          tests_failed;

  ex_stage_unit #(.WIDTH(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .ReadData1      (ReadData1),
    .ReadData2      (ReadData2),
    .PC             (PC),
    .ALU_or_DT      (ALU_or_DT),
    .BR_to_shift    (BR_to_shift),
    .alu_result_mem (alu_result_mem),
    .alu_result_wb  (alu_result_wb),
    .ALUop          (ALUop),
    .forwardA       (forwardA),
    .forwardB       (forwardB),
    .ALUsrc         (ALUsrc),
    .update         (update),
    .cbz_id         (cbz_id),
    .alu_result     (alu_result),
    .new_PC2        (new_PC2),
    .negative       (negative),
    .zero           (zero),
    .overflow       (overflow),
    .carry_out      (carry_out)
  );

  always #5 clk = ~clk;

  // Operand A as the execute stage should see it.
  function automatic logic [63:0] ref_a();
`ifdef EX_FORWARDING_EN
    if (forwardA == 2'b01) return alu_result_wb;
    if (forwardA == 2'b10) return alu_result_mem;
`endif
    return ReadData1;
  endfunction

  // Operand B as the execute stage should see it.
  function automatic logic [63:0] ref_b();
`ifdef EX_FORWARDING_EN
    if (forwardB == 2'b01) return alu_result_wb;
    if (forwardB == 2'b10) return alu_result_mem;
`endif
    return ALUsrc ? ALU_or_DT : ReadData2;
  endfunction

  // Reference ALU built from the arithmetic rules.
  function automatic alu_t ref_alu(input logic [2:0] op,
                                   input logic [63:0] a,
                                   input logic [63:0] b);
    alu_t o;
    o = '0;
    case (op)
      3'b000: o.r = b;
      3'b010: begin
        o.r = a + b;
        o.c = (o.r < a);
        o.v = (a[63] == b[63]) && (o.r[63] != a[63]);
      end
      3'b011: begin
        o.r = a - b;
        o.c = (a >= b);
        o.v = (a[63] != b[63]) && (o.r[63] != a[63]);
      end
      3'b100:  o.r = a & b;
      3'b101:  o.r = a | b;
      3'b110:  o.r = a ^ b;
      default: o.r = 64'd0;
    endcase
    o.n = o.r[63];
    o.z = (o.r == 64'd0);
    return o;
  endfunction

  // Clock edge with the flag model updated from the inputs present at
  // that edge. Returns one time unit after the edge.
  task automatic tick();
    alu_t m;
    m = ref_alu(ALUop, ref_a(), ref_b());
    if (reset) m_flags = 4'b0000;
    else if (update) m_flags = {m.n, m.z, m.v, m.c};
    @(posedge clk);
    #1;
  endtask

  // Drives one operation onto the inputs. No checking is done here.
  task automatic applyStimulus(input logic [2:0] op,
                               input logic [63:0] rd1,
                               input logic [63:0] rd2,
                               input logic src,
                               input logic [63:0] imm,
                               input logic upd);
    ALUop     = op;
    ReadData1 = rd1;
    ReadData2 = rd2;
    ALUsrc    = src;
    ALU_or_DT = imm;
    update    = upd;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tests_run++;
    if ({negative, zero, overflow, carry_out} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags got=%b exp=0000",
               {negative, zero, overflow, carry_out});
    end
  endtask

  // Test-plan items 1 to 4: add, immediate, negative result, subtract
  // and signed overflow.
  task automatic test_alu_flags();
    applyStimulus(3'b010, 64'h2AA, 64'h155, 1'b0, 64'd0, 1'b0);
    PC = 64'd0;
    BR_to_shift = 64'd2;
    #1;
    tests_run++;
    if (alu_result !== 64'h3FF) begin
      tests_failed++;
      $display("[TB] FAIL add_result got=%h exp=%h", alu_result, 64'h3FF);
    end
    tests_run++;
    if (new_PC2 !== 64'h8) begin
      tests_failed++;
      $display("[TB] FAIL br_target1 got=%h exp=%h", new_PC2, 64'h8);
    end
    tick();
    tests_run++;
    if ({negative, zero, overflow, carry_out} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL add_flags_held got=%b exp=0000",
               {negative, zero, overflow, carry_out});
    end

    applyStimulus(3'b010, 64'h2AA, 64'h155, 1'b1, 64'd1, 1'b1);
    BR_to_shift = 64'h80;
    #1;
    tests_run++;
    if (alu_result !== 64'h2AB) begin
      tests_failed++;
      $display("[TB] FAIL imm_result got=%h exp=%h", alu_result, 64'h2AB);
    end
    tests_run++;
    if (new_PC2 !== 64'h200) begin
      tests_failed++;
      $display("[TB] FAIL br_target2 got=%h exp=%h", new_PC2, 64'h200);
    end
    tick();
    tests_run++;
    if ({negative, zero, overflow, carry_out} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL imm_flags got=%b exp=0000",
               {negative, zero, overflow, carry_out});
    end

    applyStimulus(3'b010, 64'hFFFF_FFFF_FFFF_FAAA, 64'd0, 1'b1, 64'd1, 1'b0);
    #1;
    tests_run++;
    if (alu_result !== 64'hFFFF_FFFF_FFFF_FAAB) begin
      tests_failed++;
      $display("[TB] FAIL neg_result got=%h exp=%h", alu_result,
               64'hFFFF_FFFF_FFFF_FAAB);
    end
    tick();
    tests_run++;
    if ({negative, zero, overflow, carry_out} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL neg_flags_held got=%b exp=0000",
               {negative, zero, overflow, carry_out});
    end
    update = 1'b1;
    tick();
    tests_run++;
    if ({negative, zero, overflow, carry_out} !== 4'b1000) begin
      tests_failed++;
      $display("[TB] FAIL neg_flags_upd got=%b exp=1000",
               {negative, zero, overflow, carry_out});
    end

    applyStimulus(3'b011, 64'd5, 64'd5, 1'b0, 64'd0, 1'b1);
    tick();
    tests_run++;
    if ({negative, zero, overflow, carry_out} !== 4'b0101) begin
      tests_failed++;
      $display("[TB] FAIL sub_eq_flags got=%b exp=0101",
               {negative, zero, overflow, carry_out});
    end

    applyStimulus(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1);
    tick();
    tests_run++;
    if ({negative, zero, overflow, carry_out} !== 4'b1010) begin
      tests_failed++;
      $display("[TB] FAIL ovf_flags got=%b exp=1010",
               {negative, zero, overflow, carry_out});
    end
  endtask

  // Test-plan item 5: the registered Z is 0 here, and CBZ sees the live
  // zero without waiting for an edge.
  task automatic test_cbz_bypass();
    applyStimulus(3'b000, 64'd9, 64'd0, 1'b0, 64'd0, 1'b0);
    cbz_id = 1'b1;
    #1;
    tests_run++;
    if (zero !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL cbz_live got=%b exp=1", zero);
    end
    cbz_id = 1'b0;
    #1;
    tests_run++;
    if (zero !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL cbz_drop got=%b exp=0", zero);
    end
  endtask

  // Test-plan item 6: forwarding, the 11 fallback code, and reset
  // overriding update.
  task automatic test_forwarding();
    logic [63:0] exp_r;
    applyStimulus(3'b010, 64'd100, 64'd200, 1'b0, 64'd7, 1'b0);
    alu_result_mem = 64'h10;
    alu_result_wb  = 64'h3;
    forwardA = 2'b10;
    forwardB = 2'b01;
    #1;
`ifdef EX_FORWARDING_EN
    exp_r = 64'h13;
`else
    exp_r = 64'd300;
`endif
    tests_run++;
    if (alu_result !== exp_r) begin
      tests_failed++;
      $display("[TB] FAIL fwd_sel got=%h exp=%h", alu_result, exp_r);
    end

    forwardA = 2'b11;
    forwardB = 2'b11;
    ALUsrc = 1'b1;
    #1;
    tests_run++;
    if (alu_result !== 64'd107) begin
      tests_failed++;
      $display("[TB] FAIL fwd_11 got=%h exp=%h", alu_result, 64'd107);
    end
    forwardA = 2'b00;
    forwardB = 2'b00;

    applyStimulus(3'b011, 64'd1, 64'd2, 1'b0, 64'd0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    update = 1'b0;
    tests_run++;
    if ({negative, zero, overflow, carry_out} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_over_update got=%b exp=0000",
               {negative, zero, overflow, carry_out});
    end
  endtask

  // Random operations checked against the reference model. Operands are
  // sometimes forced to corner values so that carry and overflow occur.
  task automatic test_random();
    logic [63:0] corners [6];
    logic [63:0] v [5];
    alu_t m;
    logic [63:0] exp_pc;
    logic exp_z;
    corners[0] = 64'd0;
    corners[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    corners[2] = 64'h7FFF_FFFF_FFFF_FFFF;
    corners[3] = 64'h8000_0000_0000_0000;
    corners[4] = 64'd1;
    corners[5] = 64'hC000_0000_0000_0001;
    for (int i = 0; i < 200; i++) begin
      for (int k = 0; k < 5; k++) begin
        if ($urandom_range(0, 3) == 0) v[k] = corners[$urandom_range(0, 5)];
        else v[k] = {$urandom, $urandom};
      end
      ReadData1      = v[0];
      ReadData2      = v[1];
      ALU_or_DT      = v[2];
      alu_result_mem = v[3];
      alu_result_wb  = v[4];
      PC             = {$urandom, $urandom};
      BR_to_shift    = {$urandom, $urandom};
      ALUop          = 3'($urandom_range(0, 7));
      forwardA       = 2'($urandom_range(0, 3));
      forwardB       = 2'($urandom_range(0, 3));
      ALUsrc         = 1'($urandom_range(0, 1));
      update         = 1'($urandom_range(0, 1));
      cbz_id         = 1'($urandom_range(0, 1));
      reset          = ($urandom_range(0, 15) == 0);
      #1;
      m = ref_alu(ALUop, ref_a(), ref_b());
      exp_pc = PC + BR_to_shift * 64'd4;
      exp_z = cbz_id ? m.z : m_flags[2];
      tests_run++;
      if (alu_result !== m.r) begin
        tests_failed++;
        $display("[TB] FAIL rnd_result op=%b got=%h exp=%h",
                 ALUop, alu_result, m.r);
      end
      tests_run++;
      if (new_PC2 !== exp_pc) begin
        tests_failed++;
        $display("[TB] FAIL rnd_pc got=%h exp=%h", new_PC2, exp_pc);
      end
      tests_run++;
      if (zero !== exp_z) begin
        tests_failed++;
        $display("[TB] FAIL rnd_zero_pre got=%b exp=%b", zero, exp_z);
      end
      tick();
      exp_z = cbz_id ? m.z : m_flags[2];
      tests_run++;
      if ({negative, zero, overflow, carry_out} !==
          {m_flags[3], exp_z, m_flags[1], m_flags[0]}) begin
        tests_failed++;
        $display("[TB] FAIL rnd_flags op=%b got=%b exp=%b", ALUop,
                 {negative, zero, overflow, carry_out},
                 {m_flags[3], exp_z, m_flags[1], m_flags[0]});
      end
    end
    reset = 1'b0;
    cbz_id = 1'b0;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    m_flags = 4'b0000;
    reset = 1'b1;
    applyStimulus(3'b000, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0);
    PC = 64'd0;
    BR_to_shift = 64'd0;
    alu_result_mem = 64'd0;
    alu_result_wb = 64'd0;
    forwardA = 2'b00;
    forwardB = 2'b00;
    cbz_id = 1'b0;
    test_reset();
    test_alu_flags();
    test_cbz_bypass();
    test_forwarding();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
